nios_system_player_input_pio: RTL and testbench

//  Avalon-MM slave input port carrying a hardware input (keys, joystick) back to the Nios II CPU.

---
 rtl/nios_system_player_input_pio_if.sv | 18 +
 rtl/nios_system_player_input_pio.sv | 114 +++++++++++
 tb/tb_nios_system_player_input_pio.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/nios_system_player_input_pio_if.sv
// rtl/nios_system_player_input_pio_if.sv - Avalon-MM slave s1 register bus bundle
interface nios_system_player_input_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_player_input_pio.sv
// rtl/nios_system_player_input_pio.sv - synchronised, debounced, edge-capturing input PIO with IRQ
module nios_system_player_input_pio #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  nios_system_player_input_pio_if.slave s1,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] edge_det;
  logic             wr_en;

  assign wr_en = s1.chipselect & ~s1.write_n;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      always_comb deb_d = sync2_q;
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt_q [WIDTH];
      logic [CW-1:0] cnt_d [WIDTH];

      // A bit is accepted after N+1 consecutive differing samples, so the counter tops out at N.
      always_comb begin
        deb_d = deb_q;
        for (int b = 0; b < WIDTH; b++) begin
          cnt_d[b] = cnt_q[b];
          if (sync2_q[b] == deb_q[b]) begin
            cnt_d[b] = '0;
          end else if (cnt_q[b] == CW'(DEBOUNCE_CYCLES)) begin
            deb_d[b] = sync2_q[b];
            cnt_d[b] = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
        end else begin
          for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
        end
      end
    end

    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^s1.writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = deb_q & ~deb_prev_q;
      1:       edge_det = ~deb_q & deb_prev_q;
      default: edge_det = deb_q ^ deb_prev_q;
    endcase
  end

  // Clear first, then set, so a same-cycle edge survives its own W1C.
  always_comb begin
    cap_d  = cap_q;
    mask_d = mask_q;
    if (wr_en && s1.address == 2'd3) cap_d = cap_q & ~s1.writedata[WIDTH-1:0];
    cap_d = cap_d | edge_det;
    if (wr_en && s1.address == 2'd2) mask_d = s1.writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_d = '0;
    case (s1.address)
      2'd0:    rd_d[WIDTH-1:0] = deb_q;
      2'd2:    rd_d[WIDTH-1:0] = mask_q;
      2'd3:    rd_d[WIDTH-1:0] = cap_q;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      rd_q       <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      rd_q       <= rd_d;
    end
  end

  assign s1.readdata = rd_q;
  assign irq         = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_system_player_input_pio.sv
// tb/tb_nios_system_player_input_pio.sv - self-checking bench for nios_system_player_input_pio
module tb_nios_system_player_input_pio;
  localparam int NN [3] = '{0, 4, 0};
  localparam int EE [3] = '{0, 0, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr [3];
  logic        cs   [3];
  logic        wn   [3];
  logic [31:0] wd   [3];
  logic [9:0]  in_p [3];
  logic        irq_w[3];
  logic [31:0] rd   [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_system_player_input_pio_if bus0 ();
  nios_system_player_input_pio_if bus1 ();
  nios_system_player_input_pio_if bus2 ();

  assign bus0.address = addr[0]; assign bus0.chipselect = cs[0];
  assign bus0.write_n = wn[0];   assign bus0.writedata  = wd[0];
  assign bus1.address = addr[1]; assign bus1.chipselect = cs[1];
  assign bus1.write_n = wn[1];   assign bus1.writedata  = wd[1];
  assign bus2.address = addr[2]; assign bus2.chipselect = cs[2];
  assign bus2.write_n = wn[2];   assign bus2.writedata  = wd[2];
  assign rd[0] = bus0.readdata;
  assign rd[1] = bus1.readdata;
  assign rd[2] = bus2.readdata;

  nios_system_player_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(rst_n), .s1(bus0), .in_port(in_p[0]), .irq(irq_w[0]));
  nios_system_player_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut1 (
    .clk(clk), .reset_n(rst_n), .s1(bus1), .in_port(in_p[1]), .irq(irq_w[1]));
  nios_system_player_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(rst_n), .s1(bus2), .in_port(in_p[2]), .irq(irq_w[2]));

  // Reference: hist[0] is the previous edge's sample; a bit flips once its last N+1 synchronised samples all disagree with it.
  logic [9:0]  hist  [3][8];
  logic [9:0]  m_deb [3];
  logic [9:0]  m_debd[3];
  logic [9:0]  m_cap [3];
  logic [9:0]  m_mask[3];
  logic [31:0] m_rd  [3];

  always @(posedge clk or negedge rst_n) begin
    logic [9:0] nd, ed, w1c;
    logic       alld;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 8; k++) hist[i][k] <= '0;
        m_deb[i] <= '0; m_debd[i] <= '0; m_cap[i] <= '0; m_mask[i] <= '0; m_rd[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        nd = m_deb[i];
        for (int b = 0; b < 10; b++) begin
          alld = 1'b1;
          for (int k = 1; k <= NN[i] + 1; k++)
            if (hist[i][k][b] == m_deb[i][b]) alld = 1'b0;
          if (alld) nd[b] = ~m_deb[i][b];
        end
        case (EE[i])
          0:       ed = m_deb[i] & ~m_debd[i];
          1:       ed = ~m_deb[i] & m_debd[i];
          default: ed = m_deb[i] ^ m_debd[i];
        endcase
        w1c = (cs[i] && !wn[i] && addr[i] == 2'd3) ? wd[i][9:0] : 10'd0;
        m_cap[i] <= (m_cap[i] & ~w1c) | ed;
        if (cs[i] && !wn[i] && addr[i] == 2'd2) m_mask[i] <= wd[i][9:0];
        case (addr[i])
          2'd0:    m_rd[i] <= {22'd0, m_deb[i]};
          2'd2:    m_rd[i] <= {22'd0, m_mask[i]};
          2'd3:    m_rd[i] <= {22'd0, m_cap[i]};
          default: m_rd[i] <= 32'd0;
        endcase
        m_deb[i]   <= nd;
        m_debd[i]  <= m_deb[i];
        hist[i][0] <= in_p[i];
        for (int k = 1; k < 8; k++) hist[i][k] <= hist[i][k-1];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_rd%0d", i), rd[i], m_rd[i]);
      chk($sformatf("model_irq%0d", i), {31'd0, irq_w[i]}, {31'd0, |(m_cap[i] & m_mask[i])});
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic bus_wr(input int i, input logic [1:0] a, input logic [31:0] d);
    addr[i] = a; cs[i] = 1'b1; wn[i] = 1'b0; wd[i] = d;
    step();
    cs[i] = 1'b0; wn[i] = 1'b1;
  endtask

  task automatic rd_const(input int i, input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr[i] = a;
    step();
    chk(tag, rd[i], exp);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr[i] = 2'd0; cs[i] = 1'b0; wn[i] = 1'b1; wd[i] = '0; in_p[i] = 10'h3FF;
    end
    rst_n = 1'b0;
    steps(3);
    chk("reset_rd", rd[0], 32'd0);
    chk("reset_irq", {31'd0, irq_w[0]}, 32'd0);
    for (int i = 0; i < 3; i++) in_p[i] = 10'h000;
    steps(2);
    rst_n = 1'b1;
    steps(5);

    // Rising edge with no debounce
    in_p[0] = 10'h001;
    steps(3);
    chk("t2_data_before", rd[0], 32'd0);
    step();
    chk("t2_data", rd[0], 32'h001);
    rd_const(0, 2'd3, 32'h001, "t2_cap");
    chk("t2_irq_masked", {31'd0, irq_w[0]}, 32'd0);
    bus_wr(0, 2'd2, 32'h001);
    chk("t2_irq_on", {31'd0, irq_w[0]}, 32'd1);
    bus_wr(0, 2'd3, 32'h001);
    chk("t2_irq_off", {31'd0, irq_w[0]}, 32'd0);
    rd_const(0, 2'd3, 32'h000, "t2_cap_clr");

    // Same-cycle edge and W1C: set wins
    in_p[0] = 10'h000;
    steps(6);
    rd_const(0, 2'd3, 32'h000, "t4_no_fall");
    in_p[0] = 10'h001;
    steps(3);
    bus_wr(0, 2'd3, 32'h001);
    rd_const(0, 2'd3, 32'h001, "t4_set_wins");
    chk("t4_irq", {31'd0, irq_w[0]}, 32'd1);
    bus_wr(0, 2'd3, 32'h3FF);

    // Debounce N=4: glitch rejected, held input accepted at edge 7
    addr[1] = 2'd0;
    in_p[1] = 10'h004;
    steps(3);
    in_p[1] = 10'h000;
    steps(10);
    chk("t3_glitch", rd[1], 32'd0);
    rd_const(1, 2'd3, 32'd0, "t3_nocap");
    addr[1] = 2'd0;
    in_p[1] = 10'h004;
    steps(7);
    chk("t3_before", rd[1], 32'd0);
    step();
    chk("t3_data", rd[1], 32'h004);

    // Any-edge capture, read-only data, upper bits zero
    in_p[2] = 10'h200;
    steps(5);
    rd_const(2, 2'd3, 32'h200, "t5_rise");
    bus_wr(2, 2'd3, 32'h200);
    rd_const(2, 2'd3, 32'h000, "t5_clr");
    in_p[2] = 10'h000;
    steps(5);
    rd_const(2, 2'd3, 32'h200, "t5_fall");
    in_p[2] = 10'h155;
    steps(5);
    bus_wr(2, 2'd0, 32'hFFFF_FFFF);
    bus_wr(2, 2'd1, 32'hFFFF_FFFF);
    rd_const(2, 2'd0, 32'h155, "t5_data_ro");
    rd_const(2, 2'd1, 32'h000, "t5_rsvd");
    bus_wr(2, 2'd2, 32'hFFFF_FFFF);
    for (int a = 0; a < 4; a++) begin
      addr[2] = 2'(a);
      step();
      chk($sformatf("t5_upper_a%0d", a), {10'd0, rd[2][31:10]}, 32'd0);
    end

    // Reset in the middle of a debounce
    in_p[1] = 10'h008;
    steps(2);
    rst_n = 1'b0;
    steps(2);
    for (int a = 0; a < 4; a++) begin
      addr[1] = 2'(a);
      step();
      chk($sformatf("t6_reset_a%0d", a), rd[1], 32'd0);
    end
    addr[1] = 2'd3;
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t6_nocap", rd[1], 32'd0);
    end
    steps(4);

    // Randomised traffic against the reference
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        addr[i] = 2'($urandom_range(3));
        cs[i]   = ($urandom_range(3) == 0);
        wn[i]   = 1'($urandom_range(1));
        wd[i]   = $urandom;
        if ($urandom_range(5) == 0) in_p[i] = in_p[i] ^ (10'd1 << $urandom_range(9));
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      cs[i] = 1'b0; wn[i] = 1'b1;
    end
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
